node_feeder: RTL
================

// Module: node_feeder
// PURPOSE
//  Issuing side of the node operand interface. On start, reads N_INPUTS activation/weight pairs
//  from the activation buffer and weight RAM (1-cycle synchronous read), streams them one pair
//  per beat to a node_op-style MAC with valid/ready, and sends the bias on the first beat. It
//  then captures the node's single result (valid_out/x) and presents it to the layer controller.
// PARAMETERS
//  N_INPUTS  16  pairs per node evaluation (>=2)
//  DW        16  data width of activation, weight, bias, result (two's complement)
//  AW        8   address width of activation/weight memories
// PORTS
//  clk        in   1       single clock
//  rst        in   1       reset: asynchronous, active-low
//  start      in   1       begin evaluation; sampled only in IDLE
//  act_base   in   AW      activation base address (latched on start)
//  wgt_base   in   AW      weight base address (latched on start)
//  bias       in   DW      bias value (latched on start)
//  busy       out  1       high from accepted start until result handed off
//  mem_rd_en  out  1       read strobe to both memories
//  act_addr   out  AW      activation read address
//  wgt_addr   out  AW      weight read address
//  act_rdata  in   DW      activation data, valid the cycle after mem_rd_en
//  wgt_rdata  in   DW      weight data, valid the cycle after mem_rd_en
//  op_valid   out  1       operand beat valid to node
//  op_ready   in   1       node accepts beat
//  op_act     out  DW      activation operand
//  op_wgt     out  DW      weight operand
//  op_bias    out  DW      bias; meaningful only when op_first=1, else 0
//  op_first   out  1       first beat of evaluation
//  op_last    out  1       beat N_INPUTS-1
//  node_valid in   1       node result strobe (single cycle)
//  node_x     in   DW      node result
//  res_valid  out  1       result available to controller
//  res_ready  in   1       controller accepts result
//  res_data   out  DW      result
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters 0; FIFO empty. Async assert, sync-released usage.
//  FSM: IDLE -start-> STREAM; STREAM -last beat accepted-> WAIT_RES; WAIT_RES -node_valid->
//   HOLD; HOLD -res_valid&&res_ready-> IDLE. busy = (state!=IDLE).
//  Read issue: rd_cnt 0..N_INPUTS-1; addr = base+rd_cnt (mod 2^AW, wrap allowed). Issue when
//   STREAM, rd_cnt<N_INPUTS, and (fifo_count + inflight) < 2. First read in cycle after start.
//  Read data enters 2-entry operand FIFO on cycle after mem_rd_en; op_* driven from FIFO head;
//   op_valid = FIFO non-empty. Beat transfers when op_valid&&op_ready; op_* stable while stalled.
//  beat_cnt counts accepted beats; op_first at beat_cnt==0, op_last at beat_cnt==N_INPUTS-1.
//  Min latency start->op_valid: 2 cycles; full rate 1 beat/cycle with op_ready held high.
//  node_valid outside WAIT_RES: ignored, sticky err flag set (internal, visible to bench).
//  node_valid in same cycle as last beat acceptance: captured (treated as WAIT_RES entry).
//  HOLD: res_valid=1, res_data stable until res_ready; res_valid&&res_ready in HOLD and start
//   same cycle: start ignored (sampled only in IDLE).
//  start while busy: ignored. Reset mid-operation: abort, FIFO flushed, no res_valid emitted.
// CONFIGURATION
//  NODE_FEEDER_RELU_EN defined: res_data = node_x[DW-1] ? 0 : node_x (ReLU at capture).
//  Not defined: res_data = node_x unmodified. Timing/handshake identical either way.
// STRUCTURE
//  Package cnn_pkg: typedef state enum {IDLE,STREAM,WAIT_RES,HOLD}; operand struct
//   {act,wgt,first,last}; DW default constant.
//  Sub-module: node_feeder_fifo (2-entry, parameterised width, count output) for operand path.
// TESTING
//  1 start, act_base=0x10, wgt_base=0x80, op_ready=1 -> 16 beats consecutive, addr 0x10..0x1F,
//    op_first on beat0 with op_bias=bias, op_last on beat15.
//  2 op_ready toggling 1/0 each cycle -> no beat lost or duplicated, op_* stable while stalled,
//    never >2 reads outstanding.
//  3 act_base=0xF8 (AW=8) -> addresses wrap 0xF8..0xFF,0x00..0x07.
//  4 node_x=0xFFF0 -> res_data=0x0000 with NODE_FEEDER_RELU_EN, 0xFFF0 without; res_ready
//    held low 5 cycles -> res_valid/res_data stable, then IDLE.
//  5 rst low at beat 7 -> all outputs 0 immediately, next start runs clean 16-beat sequence.
//  6 start pulsed while busy and node_valid in IDLE -> both ignored, err flag set for latter.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types for the node operand path: FSM state encoding and the operand
// record carried through the operand FIFO.
package cnn_pkg;

  localparam int CNN_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  typedef struct packed {
    logic [CNN_DW-1:0] act;
    logic [CNN_DW-1:0] wgt;
    logic              first;
    logic              last;
  } operand_t;

  function automatic logic [CNN_DW-1:0] relu(input logic [CNN_DW-1:0] x);
    return x[CNN_DW-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/node_feeder_fifo.sv
// Two-entry operand FIFO with fall-through: when empty, incoming data is
// presented at the head in the same cycle so the stream can run at full rate.
module node_feeder_fifo #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic w_empty;
  logic w_pop;
  logic w_write;
  logic w_read;

  assign w_empty = (r_count == 2'd0);
  assign o_valid = !w_empty || i_push;
  assign o_data  = w_empty ? i_data : r_mem[r_rd_ptr];
  assign o_count = r_count;

  // A bypassed entry that is consumed immediately is never stored.
  assign w_pop   = i_pop && o_valid;
  assign w_write = i_push && !(w_empty && w_pop);
  assign w_read  = w_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_read) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_write} - {1'b0, w_read};
    end
  end

endmodule

// File: rtl/node_feeder.sv
// Operand issuer for one node evaluation: reads activation/weight pairs, streams them
// to the MAC, captures its result. NODE_FEEDER_RELU_EN clamps negative results to 0.
module node_feeder
  import cnn_pkg::*;
#(
  parameter int N_INPUTS = 16,
  parameter int DW       = CNN_DW,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [AW-1:0] i_act_base,
  input  logic [AW-1:0] i_wgt_base,
  input  logic [DW-1:0] i_bias,
  output logic          o_busy,
  output logic          o_mem_rd_en,
  output logic [AW-1:0] o_act_addr,
  output logic [AW-1:0] o_wgt_addr,
  input  logic [DW-1:0] i_act_rdata,
  input  logic [DW-1:0] i_wgt_rdata,
  output logic          o_op_valid,
  input  logic          i_op_ready,
  output logic [DW-1:0] o_op_act,
  output logic [DW-1:0] o_op_wgt,
  output logic [DW-1:0] o_op_bias,
  output logic          o_op_first,
  output logic          o_op_last,
  input  logic          i_node_valid,
  input  logic [DW-1:0] i_node_x,
  output logic          o_res_valid,
  input  logic          i_res_ready,
  output logic [DW-1:0] o_res_data
);

  localparam int CW = $clog2(N_INPUTS + 1);
  localparam int OW = $bits(operand_t);

  generate
    if (DW != CNN_DW) begin : g_dw_check
      $error("node_feeder: DW must match cnn_pkg::CNN_DW");
    end
  endgenerate

  state_t        r_state;
  logic [AW-1:0] r_act_base;
  logic [AW-1:0] r_wgt_base;
  logic [DW-1:0] r_bias;
  logic [CW-1:0] r_rd_cnt;
  logic          r_inflight;
  logic          r_tag_first;
  logic          r_tag_last;
  logic [DW-1:0] r_res_data;
  logic          r_err;

  operand_t      w_push_op;
  operand_t      w_head;
  logic          w_fifo_valid;
  logic [1:0]    w_fifo_count;
  logic          w_fifo_pop;
  logic          w_accept;
  logic          w_last_acc;
  logic          w_rd_en;
  logic          w_node_take;
  logic [DW-1:0] w_res_in;

  // At most two reads are outstanding (stored + in flight), so the FIFO never overflows.
  assign w_rd_en = (r_state == ST_STREAM) && (r_rd_cnt < CW'(N_INPUTS)) &&
                   ((w_fifo_count + {1'b0, r_inflight}) < 2'd2);

  // first/last ride with the data, tagged in read order at issue time.
  assign w_push_op = '{act: i_act_rdata, wgt: i_wgt_rdata, first: r_tag_first, last: r_tag_last};
  assign w_fifo_pop = i_op_ready && (r_state == ST_STREAM);

  node_feeder_fifo #(
    .W (OW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  (w_push_op),
    .i_pop   (w_fifo_pop),
    .o_data  (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign w_accept   = w_fifo_valid && i_op_ready;
  assign w_last_acc = w_accept && w_head.last;
  assign w_node_take = i_node_valid &&
                       ((r_state == ST_WAIT_RES) || ((r_state == ST_STREAM) && w_last_acc));

`ifdef NODE_FEEDER_RELU_EN
  assign w_res_in = relu(i_node_x);
`else
  assign w_res_in = i_node_x;
`endif

  assign o_busy      = (r_state != ST_IDLE);
  assign o_mem_rd_en = w_rd_en;
  assign o_act_addr  = w_rd_en ? (r_act_base + AW'(r_rd_cnt)) : '0;
  assign o_wgt_addr  = w_rd_en ? (r_wgt_base + AW'(r_rd_cnt)) : '0;
  assign o_op_valid  = w_fifo_valid;
  assign o_op_act    = w_fifo_valid ? w_head.act : '0;
  assign o_op_wgt    = w_fifo_valid ? w_head.wgt : '0;
  assign o_op_first  = w_fifo_valid && w_head.first;
  assign o_op_last   = w_fifo_valid && w_head.last;
  assign o_op_bias   = (w_fifo_valid && w_head.first) ? r_bias : '0;
  assign o_res_valid = (r_state == ST_HOLD);
  assign o_res_data  = r_res_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_act_base  <= '0;
      r_wgt_base  <= '0;
      r_bias      <= '0;
      r_rd_cnt    <= '0;
      r_inflight  <= 1'b0;
      r_tag_first <= 1'b0;
      r_tag_last  <= 1'b0;
      r_res_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_tag_first <= (r_rd_cnt == '0);
        r_tag_last  <= (r_rd_cnt == CW'(N_INPUTS - 1));
        r_rd_cnt    <= r_rd_cnt + 1'b1;
      end
      // A result strobe the FSM is not waiting for is dropped but remembered.
      if (i_node_valid && !w_node_take) begin
        r_err <= 1'b1;
      end
      if (w_node_take) begin
        r_res_data <= w_res_in;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_act_base <= i_act_base;
            r_wgt_base <= i_wgt_base;
            r_bias     <= i_bias;
            r_rd_cnt   <= '0;
            r_state    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_last_acc) begin
            r_state <= w_node_take ? ST_HOLD : ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          if (w_node_take) begin
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (i_res_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
